// File: rtl/seg_pkg.sv
// Shared types and constants for 7-segment display consumers.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0;

    // Codes 10..15 are deliberately dark rather than hex glyphs.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };

endpackage

// File: rtl/seg_scan_ctrl_bcd7.sv
// BCD to 7-segment decoder, purely combinational.
// Leading-zero blanking is left to the caller.
module bcd7_decode
    import seg_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_LUT[bcd_i];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment bank.
// New digits are staged in pend and committed only at frame end.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NDIG  = 4,
    parameter int unsigned PRESC = 1000,
    parameter int unsigned BLANK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [4*NDIG-1:0] ld_data,
    output logic              ld_ready,
    input  logic              lzb_en,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              frame_done
);

    localparam int unsigned CW = $clog2(PRESC);
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    scan_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    bcd_t            disp_q [NDIG];
    bcd_t            disp_d [NDIG];
    bcd_t            pend_q [NDIG];
    logic            pend_full_q, pend_full_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            frame_done_q, frame_done_d;

    logic            slot_end, frame_end, commit, accept, zrun;
    logic [NDIG-1:0] lzb_mask;
    bcd_t            cur_bcd;
    logic [6:0]      dec_seg;

    bcd7_decode u_dec (
        .bcd_i (cur_bcd),
        .seg_o (dec_seg)
    );

    always_comb begin
        slot_end  = (cnt_q == CW'(PRESC - 1));
        frame_end = slot_end && (idx_q == IW'(NDIG - 1));
        commit    = frame_end && pend_full_q;
        accept    = ld_valid && !pend_full_q;

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            S_BLANK: if (cnt_q == CW'(BLANK - 1)) state_d = S_DRIVE;
            S_DRIVE: if (slot_end)                state_d = S_BLANK;
            default:                              state_d = S_BLANK;
        endcase

        pend_full_d = pend_full_q;
        if (commit) begin
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_full_d = 1'b1;
        end

        for (int unsigned i = 0; i < NDIG; i++) begin
            disp_d[i] = commit ? pend_q[i] : disp_q[i];
        end

        // A digit is blanked only if it and every higher digit are zero.
        zrun     = 1'b1;
        lzb_mask = '0;
        for (int unsigned i = NDIG - 1; i > 0; i--) begin
            zrun        = zrun && (disp_d[i] == 4'h0);
            lzb_mask[i] = zrun;
        end

        // Outputs are computed from next-state so they line up with state_q.
        cur_bcd = disp_d[idx_d];
        an_d    = '0;
        seg_d   = SEG_BLANK;
        if (state_d == S_DRIVE) begin
            an_d[idx_d] = 1'b1;
            if (!(lzb_en && lzb_mask[idx_d])) begin
                seg_d = dec_seg;
            end
        end
        frame_done_d = (cnt_d == CW'(PRESC - 1)) && (idx_d == IW'(NDIG - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_full_q  <= 1'b0;
            an_q         <= '0;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
            for (int unsigned i = 0; i < NDIG; i++) begin
                disp_q[i] <= 4'hF;
                pend_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_full_q  <= pend_full_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            for (int unsigned i = 0; i < NDIG; i++) begin
                disp_q[i] <= disp_d[i];
                if (accept) begin
                    pend_q[i] <= ld_data[4*i +: 4];
                end
            end
        end
    end

    assign ld_ready   = !pend_full_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with NDIG=4, PRESC=6, BLANK=2.
// Expected digit frames are queued at load time and consumed as each slot drives.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int PRESC = 6;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * PRESC;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic        lzb_en = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_ready, frame_done;
    logic [3:0]  an;
    logic [6:0]  seg;

    int   total = 0;
    int   bad = 0;
    int   t = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    // Cycles since reset release, counted by the bench from its own rst_n.
    always @(posedge clk) t <= rst_n ? t + 1 : 0;

    seg_scan_ctrl #(.NDIG(NDIG), .PRESC(PRESC), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .lzb_en     (lzb_en),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial begin
        #100000;
        $display("FAIL watchdog t=%0d required finish before timeout", t);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int tt);
        if ((tt % PRESC) < BLANK) return 4'b0000;
        return 4'b0001 << ((tt / PRESC) % NDIG);
    endfunction

    function automatic void push_frame(input logic [15:0] v, input logic lzb);
        logic [6:0] s [NDIG];
        logic       z;
        logic [3:0] d;
        exp_t       e;
        z = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--) begin
            d = v[4*k +: 4];
            if (k > 0) z = z && (d == 4'h0);
            s[k] = (lzb && k > 0 && z) ? 7'h00 : ref_seg(d);
        end
        for (int k = 0; k < NDIG; k++) begin
            e.an  = 4'b0001 << k;
            e.seg = s[k];
            sbq.push_back(e);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_phase(input int p);
        while ((t % FRAME) != p) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld_valid = 1'b0;
        lzb_en = 1'b0;
        repeat (3) begin
            step();
            total++;
            if (an !== 4'b0 || seg !== 7'h00 || ld_ready !== 1'b1 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL reset_out an=%b seg=%h ld_ready=%b fd=%b required 0000/00/1/0",
                         an, seg, ld_ready, frame_done);
            end
        end
        rst_n = 1'b1;
        while (t < 5) begin
            total++;
            if (an !== exp_an(t) || seg !== 7'h00 || ld_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_frame t=%0d an=%b seg=%h rdy=%b required an=%b seg=00 rdy=1",
                         t, an, seg, ld_ready, exp_an(t));
            end
            step();
        end
    endtask

    task automatic test_load();
        total++;
        if (an !== exp_an(t) || ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_pre t=%0d an=%b rdy=%b required an=%b rdy=1", t, an, ld_ready, exp_an(t));
        end
        ld_valid = 1'b1;
        ld_data = 16'h1290;
        push_frame(16'h1290, 1'b0);
        step();
        ld_valid = 1'b0;
        while (t < FRAME) begin
            total++;
            if (ld_ready !== 1'b0 || seg !== 7'h00 || an !== exp_an(t) ||
                frame_done !== ((t % FRAME) == FRAME - 1)) begin
                bad++;
                $display("FAIL load_hold t=%0d rdy=%b seg=%h an=%b fd=%b required rdy=0 seg=00 an=%b",
                         t, ld_ready, seg, an, frame_done, exp_an(t));
            end
            step();
        end
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_ready_back t=%0d rdy=%b required 1", t, ld_ready);
        end
        for (int i = 0; i < FRAME; i++) begin
            if ((t % PRESC) >= BLANK) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL load_disp t=%0d an=%b seg=%h required queued entry", t, an, seg);
                end else begin
                    if (an !== sbq[0].an || seg !== sbq[0].seg) begin
                        bad++;
                        $display("FAIL load_disp t=%0d an=%b seg=%h required an=%b seg=%h",
                                 t, an, seg, sbq[0].an, sbq[0].seg);
                    end
                    if ((t % PRESC) == PRESC - 1) void'(sbq.pop_front());
                end
            end
            step();
        end
    endtask

    task automatic test_cadence();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            total++;
            if (an !== exp_an(t) || frame_done !== ((t % FRAME) == FRAME - 1)) begin
                bad++;
                $display("FAIL cadence t=%0d an=%b fd=%b required an=%b fd=%b",
                         t, an, frame_done, exp_an(t), (t % FRAME) == FRAME - 1);
            end
            if (frame_done === 1'b1) pulses++;
            step();
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL cadence_pulses got=%0d required 2", pulses);
        end
    endtask

    task automatic test_lzb();
        to_phase(1);
        ld_valid = 1'b1;
        ld_data = 16'h0070;
        push_frame(16'h0070, 1'b1);
        push_frame(16'h0070, 1'b0);
        step();
        ld_valid = 1'b0;
        to_phase(0);
        for (int f = 0; f < 2; f++) begin
            lzb_en = (f == 0);
            for (int i = 0; i < FRAME; i++) begin
                if ((t % PRESC) >= BLANK) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL lzb_disp t=%0d an=%b seg=%h required queued entry", t, an, seg);
                    end else begin
                        if (an !== sbq[0].an || seg !== sbq[0].seg) begin
                            bad++;
                            $display("FAIL lzb_disp lzb=%0d t=%0d an=%b seg=%h required an=%b seg=%h",
                                     lzb_en, t, an, seg, sbq[0].an, sbq[0].seg);
                        end
                        if ((t % PRESC) == PRESC - 1) void'(sbq.pop_front());
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        lzb_en = 1'b0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            if (c < 3 * FRAME) begin
                total++;
                if (ld_ready !== ((t % FRAME) == 0)) begin
                    bad++;
                    $display("FAIL b2b_ready t=%0d rdy=%b required %b", t, ld_ready, (t % FRAME) == 0);
                end
            end
            if (c >= FRAME && (t % PRESC) >= BLANK) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_disp t=%0d an=%b seg=%h required queued entry", t, an, seg);
                end else begin
                    if (an !== sbq[0].an || seg !== sbq[0].seg) begin
                        bad++;
                        $display("FAIL b2b_disp t=%0d an=%b seg=%h required an=%b seg=%h",
                                 t, an, seg, sbq[0].an, sbq[0].seg);
                    end
                    if ((t % PRESC) == PRESC - 1) void'(sbq.pop_front());
                end
            end
            if (c < 3 * FRAME) begin
                for (int k = 0; k < NDIG; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
                ld_valid = 1'b1;
                ld_data = v;
                if ((t % FRAME) == 0) push_frame(v, 1'b0);
            end else begin
                ld_valid = 1'b0;
            end
            step();
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL b2b_leftover entries=%0d required 0", sbq.size());
        end
    endtask

    task automatic test_mid_reset();
        to_phase(1);
        ld_valid = 1'b1;
        ld_data = 16'h4321;
        step();
        ld_valid = 1'b0;
        to_phase(15);
        total++;
        if (an !== 4'b0100) begin
            bad++;
            $display("FAIL mreset_pre an=%b required 0100", an);
        end
        rst_n = 1'b0;
        step();
        total++;
        if (an !== 4'b0 || seg !== 7'h00 || ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL mreset_out an=%b seg=%h rdy=%b required 0000/00/1", an, seg, ld_ready);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            total++;
            if (an !== exp_an(t) || seg !== 7'h00 || ld_ready !== 1'b1) begin
                bad++;
                $display("FAIL mreset_after t=%0d an=%b seg=%h rdy=%b required an=%b seg=00 rdy=1",
                         t, an, seg, ld_ready, exp_an(t));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_cadence();
        test_lzb();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display bank. It sequences the shared segment bus across digits: one digit enable at a time, with a blanking gap between digits to suppress ghosting. It accepts new BCD values through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the numeric datapath, which produces BCD digits, and the display pins, and it owns the BCD-to-segment decode.

## Interface
- NDIG, 4: number of digits; legal range 2..8.
- PRESC, 1000: clock cycles per digit slot; must be greater than BLANK.
- BLANK, 8: cycles at the start of each slot with all anodes off; must be 1 or more.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ld_valid  in  1  ld_data is offered.
- ld_data  in  4*NDIG  BCD digits; digit 0 (least significant) is in [3:0].
- ld_ready  out  1  controller can accept a load.
- lzb_en  in  1  leading-zero blanking enable; sampled every cycle.
- an  out  NDIG  one-hot digit enable, active-high; all zero while blanking.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Registers: disp[NDIG] and pend[NDIG] (4 bits each), pend_full, dig_idx, slot counter cnt (width $clog2(PRESC)), state in {S_BLANK, S_DRIVE}.
- Reset values:
  - an=0, seg=0, frame_done=0, ld_ready=1.
  - disp=all 4'hF (display blank), pend_full=0, dig_idx=0, cnt=0, state=S_BLANK.
- Handshake:
  - A transfer occurs on any cycle where ld_valid and ld_ready are both 1. It captures ld_data into pend and sets pend_full.
  - ld_ready equals !pend_full.
- Commit:
  - Happens on the last cycle of digit NDIG-1's slot while pend_full=1.
  - disp takes pend and pend_full clears, so ld_ready returns to 1 on the next cycle.
- Scan FSM:
  - S_BLANK lasts BLANK cycles, then S_DRIVE.
  - S_DRIVE lasts PRESC-BLANK cycles, then S_BLANK with dig_idx advanced modulo NDIG. cnt restarts every slot.
- Decode:
  - 0..9 map to standard segments.
  - e is lit for digits 0, 2, 6 and 8 only, matching the existing e-segment decoder.
  - Codes 10..15 produce seg=0.
- Leading-zero blanking: when lzb_en=1, a digit is blanked (seg=0) if it and every more-significant digit of disp are 0. Digit 0 is never blanked by this rule.
- frame_done pulses on the same cycle as the slot end of digit NDIG-1, whether or not a commit happens.

## Timing
- an and seg are registered. During S_DRIVE of slot k, an=1<<k and seg=decode(disp[k]).
- During S_BLANK, an=0 and seg=0.
- Slot length is exactly PRESC cycles; frame length is NDIG*PRESC cycles.
- Commit latency: from handshake to first display is up to NDIG*PRESC + BLANK + 1 cycles.
- New data first appears in slot 0 of the next frame.
- Simultaneous handshake and commit: impossible by construction, because ld_ready=0 whenever pend_full=1.
- A load accepted on the commit cycle itself cannot occur; it is held until the following cycle.
- Reset asserted mid-slot: on the next edge all registers return to reset values, an/seg go to 0, and any pending load is discarded.
- cnt and dig_idx wrap without a terminal dead cycle.

## Structure
- Shared package seg_pkg holds:
  - the SEG_BLANK constant (7'b0);
  - the typedef bcd_t (4 bits);
  - the 16-entry segment lookup constant.
- Sub-module bcd7_decode: combinational, bcd_t to 7-bit seg, no lzb logic. It is reused by any other display consumer.
- Scan FSM, counters, handshake and commit logic stay in seg_scan_ctrl.

## Test plan
All scenarios use NDIG=4, PRESC=6, BLANK=2.
- Reset: hold rst_n=0 for 3 cycles, then release. Required: an=0, seg=0 and ld_ready=1 during reset. For the first frame, each S_DRIVE shows an one-hot with seg=0 (disp=F).
- Load 16'h1290 at cycle 5. Required:
  - ld_ready=0 from cycle 6 until the frame end at cycle 24.
  - From frame 2: digit0 seg=7'h3F (e lit), digit1 seg=7'h6F, digit2 seg=7'h5B (e lit), digit3 seg=7'h06.
- Scan cadence: per slot, an=0 for 2 cycles and one-hot for 4 cycles. frame_done pulses every 24 cycles.
- Leading-zero blanking: load 16'h0070 with lzb_en=1. Required: digits 3 and 2 give seg=0, digit1 gives 7'h07, digit0 gives 7'h3F. With lzb_en=0, digits 3 and 2 give 7'h3F.
- Back-pressure: hold ld_valid=1 and change ld_data every cycle. Required: exactly one transfer per frame; disp equals the value present on each accept cycle.
- Mid-slot reset during digit 2 S_DRIVE with a pending load. Required: an=0 and seg=0 on the next cycle; after release, disp=F and the pending data never appears.
